// File: rtl/macc_pkg.sv
// Shared types for the matrix-multiply sequencer: FSM states and the
// operand-pipeline entry that travels from read issue to the MAC and C write.
package macc_pkg;

    // Widest C address the pipeline entry can carry; the top truncates to its own width.
    localparam int AW_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              first;   // k == 0: MAC loads instead of accumulating
        logic              last;    // k == N-1: MAC result is final, write C
        logic [AW_MAX-1:0] c_addr;
    } pipe_entry_t;

endpackage

// File: rtl/macc_op_pipe.sv
// Delay line of issue entries. It covers the operand read latency plus one
// stage for the MAC itself. A single hold freezes every stage at once.
module macc_op_pipe
    import macc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        hold,
    input  pipe_entry_t din,
    output pipe_entry_t mac_tap,
    output pipe_entry_t we_tap,
    output logic        inflight
);

    pipe_entry_t [DEPTH-1:0] stg;

    // Shift entries one stage per unstalled cycle.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            stg <= '0;
        end else if (!hold) begin
            stg[0] <= din;
            for (int s = 1; s < DEPTH; s++) stg[s] <= stg[s-1];
        end
    end

    // Any entry still ahead of the final (C write) stage.
    always_comb begin
        inflight = 1'b0;
        for (int s = 0; s < DEPTH-1; s++) inflight = inflight | stg[s].valid;
    end

    assign mac_tap = stg[DEPTH-2];
    assign we_tap  = stg[DEPTH-1];

endmodule

// File: rtl/macc_seq_ctrl.sv
// Sequencer for C = A x B with N = 2^n_log2. It walks (i, j, k) with k
// innermost and issues one A/B read per cycle. The MAC and C-write strobes
// are driven from the operand pipeline.
module macc_seq_ctrl
    import macc_pkg::*;
#(
    parameter int MSB    = 11,
    parameter int RD_LAT = 1,
    parameter int NLW    = 4
) (
    input  logic           CLK,
    input  logic           RST_L,
    input  logic           start,
    input  logic [NLW-1:0] n_log2,
    input  logic           stall,
    output logic [MSB:0]   a_addr,
    output logic [MSB:0]   b_addr,
    output logic           rd_en,
    output logic           mac_en,
    output logic           mac_clr,
    output logic           c_we,
    output logic [MSB:0]   c_addr,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int          AW    = MSB + 1;
    localparam logic [31:0] AW_U  = 32'(AW);

    state_t         state;
    logic [NLW-1:0] n;
    logic [MSB:0]   ci, cj, ck;
    logic [MSB:0]   ni, nj, nk;
    logic [MSB:0]   nmask;
    logic           is_last;
    logic           start_ok;
    logic           inflight;
    pipe_entry_t    din, mac_tap, we_tap;
    logic           unused_tap;

    assign nmask    = ~({AW{1'b1}} << n);
    assign is_last  = (ck == nmask) && (cj == nmask) && (ci == nmask);
    // i*N+k and k*N+j must both fit the address bus.
    assign start_ok = (({{(32-NLW){1'b0}}, n_log2} << 1) <= AW_U);

    // Successor index: k wraps into j, and j wraps into i.
    always_comb begin
        ni = ci;
        nj = cj;
        nk = ck + 1'b1;
        if (ck == nmask) begin
            nk = '0;
            nj = cj + 1'b1;
            if (cj == nmask) begin
                nj = '0;
                ni = ci + 1'b1;
            end
        end
    end

    // Control FSM with index counters and registered address/status outputs.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state  <= IDLE;
            n      <= '0;
            ci     <= '0;
            cj     <= '0;
            ck     <= '0;
            a_addr <= '0;
            b_addr <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state  <= RUN;
                            n      <= n_log2;
                            ci     <= '0;
                            cj     <= '0;
                            ck     <= '0;
                            a_addr <= '0;
                            b_addr <= '0;
                            busy   <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (is_last) begin
                            // Counters and addresses stay on the final index.
                            state <= DRAIN;
                        end else begin
                            ci     <= ni;
                            cj     <= nj;
                            ck     <= nk;
                            a_addr <= (ni << n) | nk;
                            b_addr <= (nk << n) | nj;
                        end
                    end
                end
                DRAIN: begin
                    // Leave only once the final C write is actually emitted (not stalled).
                    if (!stall && !inflight) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        din        = '0;
        din.valid  = (state == RUN);
        din.first  = (ck == '0);
        din.last   = (ck == nmask);
        din.c_addr = AW_MAX'((ci << n) | cj);
    end

    macc_op_pipe #(.DEPTH(RD_LAT + 1)) u_pipe (
        .CLK      (CLK),
        .RST_L    (RST_L),
        .hold     (stall),
        .din      (din),
        .mac_tap  (mac_tap),
        .we_tap   (we_tap),
        .inflight (inflight)
    );

    // Stall suppresses every strobe in the cycle it is seen; the pipeline simply holds.
    assign rd_en   = (state == RUN) & ~stall;
    assign mac_en  = mac_tap.valid & ~stall;
    assign mac_clr = mac_en & mac_tap.first;
    assign c_we    = we_tap.valid & we_tap.last & ~stall;
    assign c_addr  = we_tap.c_addr[MSB:0];

    assign unused_tap = ^{mac_tap.last, mac_tap.c_addr, we_tap.first, we_tap.c_addr};

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Bench for macc_seq_ctrl. An event-level model places every issue, MAC and
// C write on an "unstalled cycle" timeline and maps it back to real cycles.
// A negedge process compares every DUT output against that model.
module tb_macc_seq_ctrl;

    localparam int MSB = 11, RD_LAT = 1, NLW = 4, AW = MSB + 1, LEN = 256;

    logic           CLK = 1'b0, RST_L = 1'b0, start = 1'b0, stall = 1'b0;
    logic [NLW-1:0] n_log2 = '0;
    logic [MSB:0]   a_addr, b_addr, c_addr;
    logic           rd_en, mac_en, mac_clr, c_we, busy, done, err;

    macc_seq_ctrl #(.MSB(MSB), .RD_LAT(RD_LAT), .NLW(NLW)) dut (
        .CLK(CLK), .RST_L(RST_L), .start(start), .n_log2(n_log2), .stall(stall),
        .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en), .mac_en(mac_en),
        .mac_clr(mac_clr), .c_we(c_we), .c_addr(c_addr), .busy(busy),
        .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_bad = 0;
    int rel = 0, end_cyc = 0, st_lo = 0, st_hi = -1;
    bit chk_on = 1'b0;

    bit e_rd[LEN], e_mac[LEN], e_clr[LEN], e_we[LEN];
    bit e_busy[LEN], e_done[LEN], e_err[LEN], e_achk[LEN];
    int e_a[LEN], e_b[LEN], e_ca[LEN];

    task automatic chk_bit(input string nm, input logic act, input bit exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, rel, act, exp);
        end
    endtask

    task automatic chk_val(input string nm, input logic [MSB:0] act, input int exp);
        logic [MSB:0] e;
        e = AW'(exp);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, rel, act, e);
        end
    endtask

    // Pins the model itself against hand-derived numbers.
    task automatic pin(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL model %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Real cycle (counting from 1) of the e-th cycle that is not stalled.
    function automatic int real_cyc(input int e);
        int c, cnt;
        c = 0;
        cnt = 0;
        while (cnt < e) begin
            c++;
            if (!(c >= st_lo && c <= st_hi)) cnt++;
        end
        return c;
    endfunction

    // Expected per-cycle outputs for a start in cycle 0 with dimension 2^nl.
    task automatic build(input int nl);
        int nn, q, r, rw, rm, rdn, last_r, la, lb;
        for (int c = 0; c < LEN; c++) begin
            e_rd[c] = 0; e_mac[c] = 0; e_clr[c] = 0; e_we[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; e_achk[c] = 0;
            e_a[c] = 0; e_b[c] = 0; e_ca[c] = 0;
        end
        if (2 * nl > AW) begin
            e_err[1] = 1;
            end_cyc = 4;
            return;
        end
        nn = 1 << nl;
        q = 0; last_r = 0; la = 0; lb = 0;
        for (int i = 0; i < nn; i++)
            for (int j = 0; j < nn; j++)
                for (int k = 0; k < nn; k++) begin
                    r = real_cyc(1 + q);
                    e_rd[r] = 1; e_achk[r] = 1;
                    e_a[r] = i * nn + k;
                    e_b[r] = k * nn + j;
                    rm = real_cyc(1 + q + RD_LAT);
                    e_mac[rm] = 1;
                    e_clr[rm] = (k == 0);
                    if (k == nn - 1) begin
                        rw = real_cyc(1 + q + RD_LAT + 1);
                        e_we[rw] = 1;
                        e_ca[rw] = i * nn + j;
                    end
                    last_r = r; la = e_a[r]; lb = e_b[r];
                    q++;
                end
        rdn = real_cyc(nn * nn * nn + RD_LAT + 1) + 1;
        e_done[rdn] = 1;
        for (int c = 1; c < rdn; c++) e_busy[c] = 1;
        end_cyc = rdn + 2;
        for (int c = last_r + 1; c <= end_cyc; c++) begin
            e_achk[c] = 1; e_a[c] = la; e_b[c] = lb;
        end
    endtask

    // Compare process: mid-cycle, all outputs against the model.
    always @(negedge CLK) begin
        if (chk_on) begin
            chk_bit("rd_en", rd_en, e_rd[rel]);
            chk_bit("mac_en", mac_en, e_mac[rel]);
            chk_bit("mac_clr", mac_clr, e_clr[rel]);
            chk_bit("c_we", c_we, e_we[rel]);
            chk_bit("busy", busy, e_busy[rel]);
            chk_bit("done", done, e_done[rel]);
            chk_bit("err", err, e_err[rel]);
            if (e_achk[rel]) begin
                chk_val("a_addr", a_addr, e_a[rel]);
                chk_val("b_addr", b_addr, e_b[rel]);
            end
            if (e_we[rel]) chk_val("c_addr", c_addr, e_ca[rel]);
        end
    end

    task automatic run(input int nl, input int slo, input int shi, input int again);
        st_lo = slo; st_hi = shi;
        build(nl);
        @(posedge CLK); #1;
        rel = 0; start = 1'b1; n_log2 = NLW'(nl); stall = 1'b0; chk_on = 1'b1;
        for (int c = 1; c <= end_cyc; c++) begin
            @(posedge CLK); #1;
            rel = c;
            start = (c == again);
            stall = (c >= slo && c <= shi);
        end
        @(posedge CLK); #1;
        chk_on = 1'b0; start = 1'b0; stall = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, " rd_en"}, rd_en, 0);
        chk_bit({tag, " mac_en"}, mac_en, 0);
        chk_bit({tag, " mac_clr"}, mac_clr, 0);
        chk_bit({tag, " c_we"}, c_we, 0);
        chk_bit({tag, " busy"}, busy, 0);
        chk_bit({tag, " done"}, done, 0);
        chk_bit({tag, " err"}, err, 0);
        chk_val({tag, " a_addr"}, a_addr, 0);
        chk_val({tag, " b_addr"}, b_addr, 0);
        chk_val({tag, " c_addr"}, c_addr, 0);
    endtask

    initial begin
        // Model pins: hand-computed timings from the block description.
        st_lo = 0; st_hi = -1; build(1);
        pin("n2 done@11", e_done[11], 1);
        pin("n2 we@4", e_we[4], 1);
        pin("n2 c_addr@10", e_ca[10], 3);
        pin("n2 b@2", e_b[2], 2);
        pin("n2 a@4", e_a[4], 1);
        pin("n2 busy@11", e_busy[11], 0);
        build(0);
        pin("n1 mac@2", e_mac[2], 1);
        pin("n1 we@3", e_we[3], 1);
        pin("n1 done@4", e_done[4], 1);
        st_lo = 3; st_hi = 5; build(1);
        pin("stall done@14", e_done[14], 1);
        pin("stall rd@3", e_rd[3], 0);
        pin("stall rd@6", e_rd[6], 1);
        st_lo = 0; st_hi = -1;

        // Reset state.
        repeat (2) @(posedge CLK);
        #1 rel = 0;
        chk_all_zero("reset");
        RST_L = 1'b1;

        run(1, 0, -1, -1);      // N=2 baseline
        run(0, 0, -1, -1);      // N=1
        run(1, 3, 5, -1);       // stall cycles 3-5
        run(7, 0, -1, -1);      // illegal size
        run(1, 0, -1, 4);       // start during RUN ignored
        run(2, 0, -1, -1);      // N=4
        run(2, 10, 12, -1);     // N=4 with stall across a row boundary

        // Mid-run reset in cycle 5.
        st_lo = 0; st_hi = -1;
        build(1);
        @(posedge CLK); #1;
        rel = 0; start = 1'b1; n_log2 = NLW'(1); chk_on = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge CLK); #1;
            rel = c; start = 1'b0;
        end
        @(posedge CLK); #1;
        chk_on = 1'b0; rel = 5; RST_L = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_L = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            rel = 100 + c;
            chk_bit("post-reset c_we", c_we, 0);
            chk_bit("post-reset rd_en", rd_en, 0);
            chk_bit("post-reset busy", busy, 0);
        end

        run(1, 0, -1, -1);      // fresh start after abort

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/macc_seq_ctrl.md
Name: macc_seq_ctrl

Overview:
- Sequencer for square matrix multiply C = A x B, with N = 2^n_log2, row-major operand and result memories.
- Walks the (i, j, k) index space and issues A and B read addresses each cycle.
- Drives the MAC's clear and accumulate controls and the C write strobe and address.
- Sits between the host start/done handshake and the operand memories plus the single MAC unit.

Parameters:
- MSB, 11, MSB of every address/index bus (address width MSB+1).
- RD_LAT, 1, operand memory read latency in cycles (>=1).
- NLW, 4, width of n_log2 input.

Ports:
- CLK  in  1  clock, all flops posedge.
- RST_L  in  1  asynchronous active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- n_log2  in  NLW  log2 of matrix dimension, captured on accepted start.
- stall  in  1  freeze issue and pipeline this cycle.
- a_addr  out  MSB+1  A read address = i*N + k.
- b_addr  out  MSB+1  B read address = k*N + j.
- rd_en  out  1  operand read issue valid.
- mac_en  out  1  MAC operands valid this cycle.
- mac_clr  out  1  with mac_en: load product instead of accumulate (k==0).
- c_we  out  1  C write strobe (MAC result final).
- c_addr  out  MSB+1  C write address = i*N + j.
- busy  out  1  high from RUN entry until pipeline drained.
- done  out  1  one-cycle pulse after last C write.
- err  out  1  one-cycle pulse: start rejected, 2*n_log2 > MSB+1.

Behaviour:
- Reset (async, RST_L=0): state IDLE; all outputs 0; counters and pipeline valids cleared. Mid-operation reset aborts immediately; no further c_we.
- States: IDLE -> RUN on start & legal n_log2. RUN -> DRAIN after issuing (N-1, N-1, N-1). DRAIN -> DONE when pipeline empty. DONE -> IDLE unconditionally. done=1 only in DONE.
- Illegal n_log2 on start: stay IDLE, err=1 next cycle.
- start outside IDLE is ignored.
- Loop order: k innermost, then j, then i; each index wraps at N-1 and carries outward. Addresses are formed by shift/OR (N power of 2); no multipliers.
- RUN, stall=0: one issue per cycle, rd_en=1.
- Issue pipeline: RD_LAT+1 stages carrying valid, first (k==0), last (k==N-1) and c_addr.
  - Issue in cycle t -> mac_en (mac_clr=first) in cycle t+RD_LAT.
  - If last, c_we with c_addr in cycle t+RD_LAT+1.
- stall=1: counters and all pipeline stages hold; rd_en, mac_en, c_we forced 0 that cycle; resume exactly where frozen. Stall in IDLE/DONE has no effect.
- busy=1 in RUN and DRAIN only.
- Total latency, no stall, from start-sample edge: N^3 + RD_LAT + 2 cycles to done.
- N=1 (n_log2=0): single issue with mac_clr and c_we, c_addr 0.
- Outputs registered; the address buses hold their last value when rd_en=0.

Decomposition:
- Shared package macc_pkg: state enum (IDLE, RUN, DRAIN, DONE) and pipeline-entry struct (valid, first, last, c_addr).
- Sub-module macc_op_pipe: parameterised RD_LAT+1 delay line of entries with global hold. Top holds the FSM and the 3-index counter.

Test Plan:
- Reset, then start with n_log2=1, RD_LAT=1, stall=0:
  - rd_en in cycles 1-8.
  - a_addr sequence 0,1,0,1,2,3,2,3.
  - b_addr sequence 0,2,1,3,0,2,1,3.
  - c_we in cycles 4,6,8,10 with c_addr 0,1,2,3.
  - done in cycle 11 only.
- n_log2=0: mac_en+mac_clr in cycle 2, c_we with c_addr 0 in cycle 3, done in cycle 4.
- n_log2=1, stall high in cycles 3-5: every rd_en/mac_en/c_we event shifts by 3 cycles; address sequence unchanged; done in cycle 14.
- n_log2=7 with MSB=11 -> err pulse in cycle 1, busy stays 0, no rd_en.
- Start re-asserted during RUN -> ignored; single done. RST_L low in cycle 5 -> all outputs 0 immediately. Fresh start afterwards repeats the first scenario's sequence.
